regfile_mp: RTL

- Parametrised successor to the fixed 32x32, 2-read/1-write core register file.
- Adds configurable data width, register count (RV32I/RV32E), read-port count, optional registered read, write-to-read bypass and a pending-write scoreboard for the decode/issue stage.
- Sits between decode (read and issue side) and writeback (write side).

---
 rtl/regfile_mp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port integer register file with optional
//            registered read, write-to-read forwarding and a pending-write
//            scoreboard for the decode/issue stage.
// Ports    : clk_i      - clock, all state updates on the rising edge
//            regrst_i   - synchronous active-high reset
//            RS_i       - NRD packed read addresses (port k at [k*AW +: AW])
//            R_o        - NRD packed read data (port k at [k*XLEN +: XLEN])
//            RVALID_o   - per-port operand valid (no pending producer)
//            RWR_EN_i   - writeback write enable
//            RD_i/WR_i  - writeback address / data
//            ISS_EN_i   - issue strobe, marks ISS_RD_i as pending
//            ISS_RD_i   - destination register of the issued instruction
//            BUSY_o     - scoreboard, bit i = register i has a pending write
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter bit SYNC_READ = 1'b0,
  parameter bit BYPASS    = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                regrst_i,
  input  logic [NRD*AW-1:0]   RS_i,
  output logic [NRD*XLEN-1:0] R_o,
  output logic [NRD-1:0]      RVALID_o,
  input  logic                RWR_EN_i,
  input  logic [AW-1:0]       RD_i,
  input  logic [XLEN-1:0]     WR_i,
  input  logic                ISS_EN_i,
  input  logic [AW-1:0]       ISS_RD_i,
  output logic [NREGS-1:0]    BUSY_o
);

  // Architectural state. Entry 0 is held at zero so x0 reads need no
  // special-casing in the read mux; synthesis collapses it to a constant.
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [NREGS-1:0]    busy_q;
  logic [NREGS-1:0]    busy_d;

  // Unregistered per-port read result, used directly or through a flop.
  logic [NRD*XLEN-1:0] rdata_d;
  logic [NRD-1:0]      rvalid_d;

  logic                wr_live;
  logic                iss_live;

  // Writes and issues to x0 are architecturally void.
  assign wr_live  = RWR_EN_i && (RD_i != '0);
  assign iss_live = ISS_EN_i && (ISS_RD_i != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) begin
      regs_d[RD_i] = WR_i;
    end
    regs_d[0] = '0;
  end

  // Clear first, then set: when a new producer issues to the register
  // being written back in the same cycle, it must remain pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_live) begin
      busy_d[RD_i] = 1'b0;
    end
    if (iss_live) begin
      busy_d[ISS_RD_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (regrst_i) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign BUSY_o = busy_q;

  // Per-port read: forwarding from the writeback port takes priority over
  // the stored value, and a forwarded operand is valid even though the
  // scoreboard bit only clears at the coming edge.
  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] rs;
    logic          fwd;

    assign rs  = RS_i[k*AW +: AW];
    assign fwd = BYPASS && RWR_EN_i && (RD_i == rs) && (rs != '0);

    assign rdata_d[k*XLEN +: XLEN] = fwd ? WR_i : regs_q[rs];
    assign rvalid_d[k]             = !busy_q[rs] || fwd;
  end

  if (SYNC_READ) begin : g_sync_read
    logic [NRD*XLEN-1:0] r_q;
    logic [NRD-1:0]      rvalid_q;

    always_ff @(posedge clk_i) begin
      if (regrst_i) begin
        r_q      <= '0;
        rvalid_q <= '1;
      end else begin
        r_q      <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign R_o      = r_q;
    assign RVALID_o = rvalid_q;
  end else begin : g_comb_read
    assign R_o      = rdata_d;
    assign RVALID_o = rvalid_d;
  end

endmodule
`default_nettype wire
